drs_fifo_unpacker: RTL

- Read-side consumer of the DRS readout byte FIFO.
- Drains the little-endian byte stream and rebuilds 16-bit words.
- Parses the per-event frame: 2 header words, then READDEPTH samples for gain channel 0, then READDEPTH samples for gain channel 1.
- Presents tagged 12-bit samples and event metadata to downstream packet logic over a valid/ready interface.
- Sits in the DFIFO read-clock domain; CLK here is that read clock.

---
 rtl/drs_fifo_unpacker_pkg.sv | 30 +++
 rtl/drs_fifo_unpacker_if.sv | 25 ++
 rtl/drs_unpack_obuf.sv | 50 +++++
 rtl/drs_fifo_unpacker.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/drs_fifo_unpacker_pkg.sv
// Shared frame layout, FSM encoding and sample record for the DRS FIFO unpacker.
package drs_fifo_unpacker_pkg;

  localparam int unsigned HDR_BYTES  = 4;
  localparam int unsigned BYTE_W     = 8;
  localparam int unsigned DEPTH_W    = 13;
  localparam int unsigned DATA_W     = 12;
  localparam int unsigned STOPCELL_W = 10;
  localparam int unsigned FLEN_W     = 16;

  // Reserved-bit masks: header word 0 B0/B1, header word 1 B1, sample B1
  localparam logic [BYTE_W-1:0] RSV_HDR0_B0 = 8'hFE;
  localparam logic [BYTE_W-1:0] RSV_HDR0_B1 = 8'hFF;
  localparam logic [BYTE_W-1:0] RSV_HDR1_B1 = 8'hF0;
  localparam logic [BYTE_W-1:0] RSV_SMP_B1  = 8'hF0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic               ch;
    logic [DEPTH_W-1:0] idx;
    logic [DATA_W-1:0]  data;
  } smp_rec_t;

endpackage

// File: rtl/drs_fifo_unpacker_if.sv
// Byte-FIFO read side and tagged sample stream of the DRS unpacker.
interface drs_fifo_unpacker_if;
  import drs_fifo_unpacker_pkg::*;

  logic [BYTE_W-1:0]  DFIFO_DOUT;
  logic               DFIFO_EMPTY;
  logic               DFIFO_VALID;
  logic               DFIFO_RD_EN;
  logic [DATA_W-1:0]  SMP_DATA;
  logic               SMP_CH;
  logic [DEPTH_W-1:0] SMP_IDX;
  logic               SMP_VALID;
  logic               SMP_READY;

  modport master (
    input  DFIFO_DOUT, DFIFO_EMPTY, DFIFO_VALID, SMP_READY,
    output DFIFO_RD_EN, SMP_DATA, SMP_CH, SMP_IDX, SMP_VALID
  );

  modport slave (
    output DFIFO_DOUT, DFIFO_EMPTY, DFIFO_VALID, SMP_READY,
    input  DFIFO_RD_EN, SMP_DATA, SMP_CH, SMP_IDX, SMP_VALID
  );

endinterface

// File: rtl/drs_unpack_obuf.sv
// Small synchronous sample FIFO with occupancy count and valid/ready head.
module drs_unpack_obuf
  import drs_fifo_unpacker_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   push_i,
  input  smp_rec_t               push_rec_i,
  input  logic                   ready_i,
  output smp_rec_t               head_o,
  output logic                   valid_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  smp_rec_t        mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW:0]     count_q;
  logic            pop_c;

  assign valid_o = (count_q != '0);
  assign pop_c   = valid_o && ready_i;
  assign head_o  = valid_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_i, pop_c})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: the head is masked while empty
  always_ff @(posedge CLK) begin
    if (push_i) mem_q[wr_ptr_q] <= push_rec_i;
  end

endmodule

// File: rtl/drs_fifo_unpacker.sv
// Drains the DRS readout byte FIFO, parses event frames and emits tagged 12-bit samples.
module drs_fifo_unpacker
  import drs_fifo_unpacker_pkg::*;
#(
  parameter int unsigned OBUF_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  ENABLE,
  input  logic [DEPTH_W-1:0]    DRS_READDEPTH,
  drs_fifo_unpacker_if.master   bus,
  output logic [STOPCELL_W-1:0] EVT_STOPCELL,
  output logic [1:0]            EVT_STOPCH,
  output logic                  EVT_STOPCH_FLAG,
  output logic                  EVT_HDR_VALID,
  output logic                  EVT_DONE,
  output logic                  FMT_ERR,
  output logic [CNT_W-1:0]      EVT_CNT,
  output logic [CNT_W-1:0]      ERR_CNT,
  output logic                  BUSY
);

  localparam int unsigned OCC_W = $clog2(OBUF_DEPTH) + 1;
  localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(OBUF_DEPTH - 3);

  state_e                  state_q, state_d;
  logic [DEPTH_W-1:0]      depth_q, idx_q;
  logic                    ch_q, flag_tmp_q;
  logic [FLEN_W-1:0]       req_cnt_q, rcv_cnt_q, flen_c;
  logic [BYTE_W-1:0]       lo_byte_q;
  logic [STOPCELL_W-1:0]   stopcell_q;
  logic [1:0]              stopch_q;
  logic                    flag_q, hdr_valid_q, evt_done_q, fmt_err_q, busy_q;
  logic [CNT_W-1:0]        evt_cnt_q, err_cnt_q;
  logic                    issue_ok_c, rd_en_c, beat_c, push_c, err_c, hdr_done_c;
  logic [OCC_W-1:0]        occ_c;
  smp_rec_t                push_rec_c, head_c;
  logic [BYTE_W-1:0]       dout_c;

  assign dout_c     = bus.DFIFO_DOUT;
  assign flen_c     = FLEN_W'({depth_q, 2'b00}) + FLEN_W'(HDR_BYTES);
  assign issue_ok_c = !bus.DFIFO_EMPTY && (req_cnt_q < flen_c) && (occ_c <= OCC_MAX);
  assign beat_c     = bus.DFIFO_VALID && ((state_q == HDR) || (state_q == DATA));
  assign push_rec_c = '{ch: ch_q, idx: idx_q, data: {dout_c[3:0], lo_byte_q}};

  // Next state, read strobe and per-byte parse decisions
  always_comb begin
    state_d    = state_q;
    rd_en_c    = 1'b0;
    push_c     = 1'b0;
    err_c      = 1'b0;
    hdr_done_c = 1'b0;
    case (state_q)
      IDLE: begin
        err_c = bus.DFIFO_VALID;
        if (ENABLE && !bus.DFIFO_EMPTY) state_d = HDR;
      end
      HDR: begin
        rd_en_c = issue_ok_c;
        if (bus.DFIFO_VALID) begin
          case (rcv_cnt_q[1:0])
            2'd0: err_c = |(dout_c & RSV_HDR0_B0);
            2'd1: err_c = |(dout_c & RSV_HDR0_B1);
            2'd3: begin
              err_c      = |(dout_c & RSV_HDR1_B1);
              hdr_done_c = 1'b1;
              state_d    = (depth_q == '0) ? DONE : DATA;
            end
            default: err_c = 1'b0;
          endcase
        end
      end
      DATA: begin
        rd_en_c = issue_ok_c;
        if (bus.DFIFO_VALID && rcv_cnt_q[0]) begin
          push_c = 1'b1;
          err_c  = |(dout_c & RSV_SMP_B1);
          if (rcv_cnt_q == flen_c - FLEN_W'(1)) state_d = DONE;
        end
      end
      DONE: begin
        err_c   = bus.DFIFO_VALID;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      depth_q     <= '0;
      idx_q       <= '0;
      ch_q        <= 1'b0;
      flag_tmp_q  <= 1'b0;
      req_cnt_q   <= '0;
      rcv_cnt_q   <= '0;
      lo_byte_q   <= '0;
      stopcell_q  <= '0;
      stopch_q    <= '0;
      flag_q      <= 1'b0;
      hdr_valid_q <= 1'b0;
      evt_done_q  <= 1'b0;
      fmt_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      evt_cnt_q   <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      fmt_err_q   <= err_c;
      hdr_valid_q <= hdr_done_c;
      evt_done_q  <= (state_d == DONE);
      busy_q      <= (state_d == HDR) || (state_d == DATA);
      if (err_c && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_W'(1);
      if (state_d == DONE) evt_cnt_q <= evt_cnt_q + CNT_W'(1);

      if (state_q == IDLE) begin
        depth_q   <= DRS_READDEPTH;
        req_cnt_q <= '0;
        rcv_cnt_q <= '0;
        ch_q      <= 1'b0;
        idx_q     <= '0;
      end else begin
        if (rd_en_c) req_cnt_q <= req_cnt_q + FLEN_W'(1);
        if (beat_c) begin
          rcv_cnt_q <= rcv_cnt_q + FLEN_W'(1);
          lo_byte_q <= dout_c;
        end
      end

      if (beat_c && (state_q == HDR) && (rcv_cnt_q[1:0] == 2'd0)) flag_tmp_q <= dout_c[0];

      if (hdr_done_c) begin
        stopcell_q <= {dout_c[1:0], lo_byte_q};
        stopch_q   <= dout_c[3:2];
        flag_q     <= flag_tmp_q;
      end

      // Channel 0 indices run first, then channel 1 restarts at 0
      if (push_c) begin
        if (idx_q == depth_q - DEPTH_W'(1)) begin
          idx_q <= '0;
          ch_q  <= 1'b1;
        end else begin
          idx_q <= idx_q + DEPTH_W'(1);
        end
      end
    end
  end

  drs_unpack_obuf #(.DEPTH(OBUF_DEPTH)) u_obuf (
    .CLK        (CLK),
    .RST        (RST),
    .push_i     (push_c),
    .push_rec_i (push_rec_c),
    .ready_i    (bus.SMP_READY),
    .head_o     (head_c),
    .valid_o    (bus.SMP_VALID),
    .count_o    (occ_c)
  );

  assign bus.DFIFO_RD_EN = rd_en_c;
  assign bus.SMP_DATA    = head_c.data;
  assign bus.SMP_CH      = head_c.ch;
  assign bus.SMP_IDX     = head_c.idx;

  assign EVT_STOPCELL    = stopcell_q;
  assign EVT_STOPCH      = stopch_q;
  assign EVT_STOPCH_FLAG = flag_q;
  assign EVT_HDR_VALID   = hdr_valid_q;
  assign EVT_DONE        = evt_done_q;
  assign FMT_ERR         = fmt_err_q;
  assign EVT_CNT         = evt_cnt_q;
  assign ERR_CNT         = err_cnt_q;
  assign BUSY            = busy_q;

endmodule
